// File: rtl/alu_core.sv
// ============================================================================
//  Module   : alu_core
//  Purpose  : 32-bit integer ALU for the execute stage. Produces a purely
//             combinational result and holds the architectural flags
//             register {V,S,Z,C} consumed by branch-condition logic.
//  Ports    : clk, rst            - clock / async active-high reset (flags)
//             opcode, alu_op      - major opcode and ALU function select
//             lhs, rhs            - 32-bit operands (already muxed upstream)
//             bubble_in           - slot is empty; blocks flag update
//             flags_restore,      - exception-return flag load ([3:0] used)
//             flags_we
//             result              - combinational 32-bit result
//             flags               - registered flags [0]=C [1]=Z [2]=S [3]=V
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic        bubble_in,
  input  logic [31:0] flags_restore,
  input  logic        flags_we,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam logic [4:0] OP_AND  = 5'd0,  OP_NAND = 5'd1,  OP_OR   = 5'd2;
  localparam logic [4:0] OP_NOR  = 5'd3,  OP_XOR  = 5'd4,  OP_XNOR = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6,  OP_LSL  = 5'd7,  OP_LSR  = 5'd8;
  localparam logic [4:0] OP_ASR  = 5'd9,  OP_ROTL = 5'd10, OP_ROTR = 5'd11;
  localparam logic [4:0] OP_LSLC = 5'd12, OP_LSRC = 5'd13, OP_ADD  = 5'd14;
  localparam logic [4:0] OP_ADDC = 5'd15, OP_SUB  = 5'd16, OP_SUBB = 5'd17;
  localparam logic [4:0] OP_MUL  = 5'd18;

  logic        c_flag;
  logic [4:0]  shamt;
  logic        is_alu;
  logic        is_sub;
  logic [31:0] addend;
  logic        carry_in;
  logic [32:0] sum33;
  logic        add_ovf;
  logic [32:0] lsl_w;
  logic [32:0] lsr_w;
  logic signed [32:0] asr_in;
  logic [32:0] asr_w;
  logic [31:0] rotl_w;
  logic [31:0] rotr_w;
  logic [31:0] mul_lo;
  logic [31:0] addr_sum;
  logic [31:0] alu_res;
  logic        alu_c;
  logic        alu_v;
  logic        unused_restore_bits;

  assign c_flag = flags[0];
  assign shamt  = rhs[4:0];
  assign is_alu = (opcode == 5'd0) || (opcode == 5'd1);

  // One adder serves add/addc/sub/subb: subtraction is lhs + ~rhs + carry,
  // so the carry out is directly the "no borrow" flag.
  assign is_sub   = (alu_op == OP_SUB) || (alu_op == OP_SUBB);
  assign addend   = is_sub ? ~rhs : rhs;
  assign carry_in = (alu_op == OP_SUB) ? 1'b1 :
                    ((alu_op == OP_ADDC) || (alu_op == OP_SUBB)) ? c_flag : 1'b0;
  assign sum33    = {1'b0, lhs} + {1'b0, addend} + {32'b0, carry_in};
  assign add_ovf  = (lhs[31] == addend[31]) && (sum33[31] != lhs[31]);

  // Shifts carry one extra bit so the last bit shifted out lands in the
  // spare position; an amount of 0 leaves that bit at 0.
  assign lsl_w  = {1'b0, lhs} << shamt;
  assign lsr_w  = {lhs, 1'b0} >> shamt;
  assign asr_in = {lhs, 1'b0};
  assign asr_w  = asr_in >>> shamt;
  // A rotate by 0 shifts the complementary term by 32, which yields 0.
  assign rotl_w = (lhs << shamt) | (lhs >> (6'd32 - {1'b0, shamt}));
  assign rotr_w = (lhs >> shamt) | (lhs << (6'd32 - {1'b0, shamt}));
  assign mul_lo = lhs * rhs;

  assign addr_sum = lhs + rhs;

  always_comb begin
    alu_res = 32'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      OP_AND:  alu_res = lhs & rhs;
      OP_NAND: alu_res = ~(lhs & rhs);
      OP_OR:   alu_res = lhs | rhs;
      OP_NOR:  alu_res = ~(lhs | rhs);
      OP_XOR:  alu_res = lhs ^ rhs;
      OP_XNOR: alu_res = ~(lhs ^ rhs);
      OP_NOT:  alu_res = ~rhs;
      OP_LSL:  begin alu_res = lsl_w[31:0]; alu_c = lsl_w[32]; end
      OP_LSR:  begin alu_res = lsr_w[32:1]; alu_c = lsr_w[0];  end
      OP_ASR:  begin alu_res = asr_w[32:1]; alu_c = asr_w[0];  end
      OP_ROTL: alu_res = rotl_w;
      OP_ROTR: alu_res = rotr_w;
      OP_LSLC: begin alu_res = {lhs[30:0], c_flag}; alu_c = lhs[31]; end
      OP_LSRC: begin alu_res = {c_flag, lhs[31:1]}; alu_c = lhs[0];  end
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBB: begin
        alu_res = sum33[31:0];
        alu_c   = sum33[32];
        alu_v   = add_ovf;
      end
      OP_MUL:  alu_res = mul_lo;
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    result = addr_sum;
    if (is_alu) begin
      result = alu_res;
    end else if (opcode == 5'd2) begin
      result = rhs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (flags_we) begin
      flags <= flags_restore[3:0];
    end else if (!bubble_in && is_alu) begin
      flags <= {alu_v, alu_res[31], (alu_res == 32'd0), alu_c};
    end
  end

  assign unused_restore_bits = ^flags_restore[31:4];

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
// ============================================================================
//  Module   : tb_alu_core
//  Purpose  : Self-checking bench for alu_core. A driver issues one
//             instruction per cycle and pushes the expected result and
//             flags into a scoreboard queue; a monitor pops and compares
//             mid-cycle. Expectations come from a wide-arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic        bubble_in;
  logic [31:0] flags_restore;
  logic        flags_we;
  logic [31:0] result;
  logic [3:0]  flags;

  alu_core dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_op(alu_op),
    .lhs(lhs), .rhs(rhs), .bubble_in(bubble_in),
    .flags_restore(flags_restore), .flags_we(flags_we),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          id;
  } exp_t;

  exp_t     sb[$];
  int       errors = 0;
  int       checks = 0;
  logic [3:0] model_flags = 4'b0000;
  int       issued = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  // Reference model: plain wide arithmetic and bit-at-a-time rotation.
  function automatic void ref_alu(input logic [4:0] opc, input logic [4:0] aop,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, output logic [31:0] r,
                                  output logic c, output logic v);
    int sh;
    longint unsigned u;
    longint s;
    logic k;
    sh = int'(b[4:0]);
    r = 32'd0; c = 1'b0; v = 1'b0;
    if (opc > 5'd2) begin
      r = a + b;
    end else if (opc == 5'd2) begin
      r = b;
    end else begin
      case (aop)
        5'd0: r = a & b;
        5'd1: r = ~(a & b);
        5'd2: r = a | b;
        5'd3: r = ~(a | b);
        5'd4: r = a ^ b;
        5'd5: r = ~(a ^ b);
        5'd6: r = ~b;
        5'd7: begin r = a << sh; c = (sh == 0) ? 1'b0 : a[32 - sh]; end
        5'd8: begin r = a >> sh; c = (sh == 0) ? 1'b0 : a[sh - 1]; end
        5'd9: begin r = $unsigned($signed(a) >>> sh); c = (sh == 0) ? 1'b0 : a[sh - 1]; end
        5'd10: begin r = a; repeat (sh) r = {r[30:0], r[31]}; end
        5'd11: begin r = a; repeat (sh) r = {r[0], r[31:1]}; end
        5'd12: begin r = (a << 1) | {31'd0, cin}; c = a[31]; end
        5'd13: begin r = ({31'd0, cin} << 31) | (a >> 1); c = a[0]; end
        5'd14, 5'd15: begin
          k = (aop == 5'd15) ? cin : 1'b0;
          u = longint'(a) + longint'(b) + longint'(k);
          r = u[31:0];
          c = u[32];
          s = longint'($signed(a)) + longint'($signed(b)) + longint'(k);
          v = (s > SMAX) || (s < SMIN);
        end
        5'd16, 5'd17: begin
          k = (aop == 5'd17) ? !cin : 1'b0;
          r = a - b - {31'd0, k};
          c = longint'(a) >= (longint'(b) + longint'(k));
          s = longint'($signed(a)) - longint'($signed(b)) - longint'(k);
          v = (s > SMAX) || (s < SMIN);
        end
        5'd18: r = a * b;
        default: r = 32'd0;
      endcase
    end
  endfunction

  // Drive one slot just after the rising edge and record what the monitor
  // must see at the following falling edge.
  task automatic issue(input logic r_in, input logic [4:0] opc, input logic [4:0] aop,
                       input logic [31:0] a, input logic [31:0] b, input logic bub,
                       input logic we, input logic [31:0] rest);
    exp_t e;
    logic [31:0] r;
    logic c, v;
    @(posedge clk);
    #1;
    rst = r_in; opcode = opc; alu_op = aop; lhs = a; rhs = b;
    bubble_in = bub; flags_we = we; flags_restore = rest;
    if (r_in) model_flags = 4'b0000;
    ref_alu(opc, aop, a, b, model_flags[0], r, c, v);
    e.res = r; e.flg = model_flags; e.id = issued;
    sb.push_back(e);
    issued++;
    if (r_in)                      model_flags = 4'b0000;
    else if (we)                   model_flags = rest[3:0];
    else if (!bub && opc <= 5'd1)  model_flags = {v, r[31], (r == 32'd0), c};
  endtask

  task automatic alu(input logic [4:0] aop, input logic [31:0] a, input logic [31:0] b);
    issue(1'b0, 5'd0, aop, a, b, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic restore(input logic [3:0] f);
    issue(1'b0, 5'd3, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, {28'hFFFFFFF, f});
  endtask

  // Monitor: one expected entry per cycle, compared away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (result !== e.res) begin
          errors++;
          $display("FAIL result slot %0d: got %h expected %h", e.id, result, e.res);
        end
        checks++;
        if (flags !== e.flg) begin
          errors++;
          $display("FAIL flags slot %0d: got %b expected %b", e.id, flags, e.flg);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  opc;
    logic [31:0] a, b;
    rst = 1'b1; opcode = 5'd0; alu_op = 5'd0; lhs = 32'd0; rhs = 32'd0;
    bubble_in = 1'b0; flags_we = 1'b0; flags_restore = 32'd0;

    issue(1'b1, 5'd0, 5'd14, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0);
    alu(5'd14, 32'h7FFFFFFF, 32'h1);          // overflow into sign
    alu(5'd16, 32'd5, 32'd5);                 // zero, no borrow
    alu(5'd16, 32'd3, 32'd5);                 // borrow, negative
    restore(4'b0001);
    alu(5'd15, 32'd1, 32'd1);                 // addc with C=1
    restore(4'b0000);
    alu(5'd17, 32'd5, 32'd2);                 // subb with C=0
    alu(5'd9,  32'h80000000, 32'd4);
    alu(5'd11, 32'h00000001, 32'd1);
    alu(5'd7,  32'hFFFFFFFF, 32'd0);          // shift by 0 leaves C=0
    alu(5'd7,  32'h80000001, 32'd1);          // C gets old bit 31
    issue(1'b0, 5'd0, 5'd16, 32'd5, 32'd5, 1'b1, 1'b0, 32'd0);   // bubble
    issue(1'b0, 5'd0, 5'd16, 32'd5, 32'd5, 1'b1, 1'b1, 32'hA);   // restore wins
    issue(1'b0, 5'd0, 5'd14, 32'd1, 32'd1, 1'b0, 1'b1, 32'h5);   // restore over ALU
    issue(1'b0, 5'd3, 5'd0, 32'h1000, 32'h10, 1'b0, 1'b0, 32'd0);
    issue(1'b0, 5'd2, 5'd0, 32'h1234, 32'hABCD0000, 1'b0, 1'b0, 32'd0);
    alu(5'd12, 32'h80000000, 32'd0);
    alu(5'd13, 32'h00000003, 32'd0);
    alu(5'd18, 32'h00010003, 32'h00020005);
    alu(5'd25, 32'h12345678, 32'h9);          // reserved
    issue(1'b1, 5'd0, 5'd4, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, 1'b0, 32'd0); // reset mid-run

    for (int i = 0; i < 400; i++) begin
      opc = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(2, 31));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) b = a;
      issue(($urandom_range(0, 39) == 0), opc, 5'($urandom_range(0, 31)), a, b,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
